uart_tx_fifo_256x8: RTL and testbench

Buffers bytes produced by the upstream `send_256_8bit` generator in a 256×8 FIFO and drains them one at a time into the UART transmitter using a start/busy handshake. It throttles the generator through `en_send`, so bytes in flight are never lost when the FIFO nears full. It sits between the byte generator and the UART TX core.

---
 rtl/uart_fifo_pkg.sv | 16 +
 rtl/fifo_ram_256x8.sv | 29 ++
 rtl/uart_tx_fifo_256x8.sv | 130 +++++++++++++
 tb/tb_uart_tx_fifo_256x8.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_pkg.sv
// Shared sizing and read-FSM state encoding for the UART TX byte FIFO.
package uart_fifo_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [4:0] rd_state_t;

    localparam rd_state_t IDLE    = 5'b00001;
    localparam rd_state_t LOAD    = 5'b00010;
    localparam rd_state_t START   = 5'b00100;
    localparam rd_state_t WAIT_HI = 5'b01000;
    localparam rd_state_t WAIT_LO = 5'b10000;

endpackage

// File: rtl/fifo_ram_256x8.sv
// Simple dual-port storage: synchronous write, registered read with one cycle of latency.
module fifo_ram_256x8
    import uart_fifo_pkg::*;
(
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // A read and write to the same slot in one cycle returns the old contents.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_tx_fifo_256x8.sv
// 256-byte buffer between the byte generator and the UART transmitter.
// State | meaning: IDLE wait for data/issue read; LOAD latch byte, pulse start;
// START drop start; WAIT_HI wait for UART busy; WAIT_LO wait for UART to finish.
module uart_tx_fifo_256x8
    import uart_fifo_pkg::*;
#(
    parameter int AF_MARGIN = 4
)
(
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              en_send,
    input  logic              uart_tx_busy,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_LVL   = (ADDR_W + 1)'(DEPTH - AF_MARGIN);

    logic              wr_en_q;
    logic              wr_stb;
    logic              wr_acc;
    logic              rd_issue;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    logic              overflow_q;
    logic              en_send_q;
    rd_state_t         state_q;
    rd_state_t         state_d;
    logic              tx_start_q;
    logic              tx_start_d;
    logic [DATA_W-1:0] tx_data_q;
    logic [DATA_W-1:0] tx_data_d;
    logic [DATA_W-1:0] ram_rdata;

    assign full     = (count_q == FULL_LVL);
    assign empty    = (count_q == '0);
    assign wr_stb   = wr_en & ~wr_en_q;
    assign rd_issue = (state_q == IDLE) & ~empty;
    // A read issued in the same cycle frees a slot, so a write at full still lands.
    assign wr_acc   = wr_stb & (~full | rd_issue);

    always_comb begin
        count_d = count_q;
        case ({wr_acc, rd_issue})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_en_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            en_send_q  <= 1'b0;
        end else begin
            wr_en_q   <= wr_en;
            count_q   <= count_d;
            en_send_q <= (count_d < AF_LVL);
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_issue) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (wr_stb & ~wr_acc) begin
                overflow_q <= 1'b1;
            end
        end
    end

    fifo_ram_256x8 u_ram (
        .clk_i   (sys_clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .re_i    (rd_issue),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty) state_d = LOAD;
            LOAD:    state_d = START;
            START:   state_d = WAIT_HI;
            WAIT_HI: if (uart_tx_busy) state_d = WAIT_LO;
            WAIT_LO: if (!uart_tx_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_start_d = (state_q == LOAD);
        tx_data_d  = (state_q == LOAD) ? ram_rdata : tx_data_q;
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign en_send  = en_send_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo_256x8.sv
// Randomised bench for uart_tx_fifo_256x8 with a queue-based reference model and a small UART busy emulator.
module tb_uart_tx_fifo_256x8;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       uart_tx_busy;
    logic       en_send;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [8:0] count;
    logic       full;
    logic       empty;
    logic       overflow;

    int n_pass  = 0;
    int n_total = 0;

    uart_tx_fifo_256x8 dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .en_send      (en_send),
        .uart_tx_busy (uart_tx_busy),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: a byte queue plus a sender described by cycle offsets from its pop.
    logic [7:0] m_q[$];
    bit         m_active;
    bit         m_hi_seen;
    bit         m_wr_prev;
    bit         m_ov;
    bit         m_en;
    bit         m_start;
    logic [7:0] m_data;
    logic [7:0] m_pend;
    int         m_cyc;
    int         m_pop_cyc;

    task automatic m_reset();
        m_q.delete();
        m_active  = 0;
        m_hi_seen = 0;
        m_wr_prev = 0;
        m_ov      = 0;
        m_en      = 0;
        m_start   = 0;
        m_data    = 8'h00;
        m_pend    = 8'h00;
        m_cyc     = 0;
        m_pop_cyc = 0;
    endtask

    task automatic m_step();
        bit b;
        bit stb;
        bit rd;
        bit acc;
        int sz;
        b         = uart_tx_busy;
        stb       = wr_en && !m_wr_prev;
        m_wr_prev = wr_en;
        sz        = m_q.size();
        m_cyc++;
        rd = 0;
        if (m_active) begin
            // Busy is only watched from three cycles after the pop onward.
            if (m_cyc >= m_pop_cyc + 3) begin
                if (!m_hi_seen) m_hi_seen = b;
                else if (!b) m_active = 0;
            end
        end else if (sz > 0) begin
            rd        = 1;
            m_pend    = m_q.pop_front();
            m_active  = 1;
            m_hi_seen = 0;
            m_pop_cyc = m_cyc;
        end
        acc = stb && (sz < 256 || rd);
        if (acc) m_q.push_back(wr_data);
        if (stb && !acc) m_ov = 1;
        m_start = m_active && (m_cyc == m_pop_cyc + 1);
        if (m_start) m_data = m_pend;
        m_en = (m_q.size() < 252);
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge sys_clk or posedge sys_rst);
            if (sys_rst) m_reset();
            else m_step();
        end
    end

    int ncyc       = 0;
    int last_start = -1000;

    initial begin
        forever begin
            @(negedge sys_clk);
            ncyc++;
            if (sys_rst) last_start = -1000;
            check("count",    32'(count),    32'(m_q.size()));
            check("full",     32'(full),     32'(m_q.size() == 256));
            check("empty",    32'(empty),    32'(m_q.size() == 0));
            check("overflow", 32'(overflow), 32'(m_ov));
            check("en_send",  32'(en_send),  32'(m_en));
            check("tx_start", 32'(tx_start), 32'(m_start));
            check("tx_data",  32'(tx_data),  32'(m_data));
            if (tx_start === 1'b1) begin
                if (last_start > -1000) check("start_gap", 32'((ncyc - last_start) >= 5), 1);
                last_start = ncyc;
            end
        end
    end

    // UART emulator: 0 = fixed-length busy pulse, 1 = busy held, 2 = busy low, 3 = random pulse length.
    int busy_mode = 0;
    int busy_len  = 1;
    int busy_left = 0;
    bit busy_pend = 0;

    initial begin
        uart_tx_busy = 1'b0;
        forever begin
            @(posedge sys_clk);
            #2;
            if (sys_rst) begin
                busy_pend    = 0;
                busy_left    = 0;
                uart_tx_busy = 1'b0;
            end else if (busy_mode == 1) begin
                uart_tx_busy = 1'b1;
            end else if (busy_mode == 2) begin
                uart_tx_busy = 1'b0;
            end else begin
                if (busy_pend) begin
                    busy_left = (busy_mode == 3) ? int'($urandom_range(1, 12)) : busy_len;
                    busy_pend = 0;
                end
                if (tx_start === 1'b1) busy_pend = 1;
                uart_tx_busy = (busy_left > 0);
                if (busy_left > 0) busy_left--;
            end
        end
    end

    task automatic push_byte(input logic [7:0] d);
        @(negedge sys_clk);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge sys_clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n;
        n = 0;
        while ((m_q.size() != 0 || m_active) && n < limit) begin
            @(negedge sys_clk);
            n++;
        end
        check({name, "_timeout"}, 32'(n < limit), 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        #1;
        check("rst_en_send",  32'(en_send),  0);
        check("rst_empty",    32'(empty),    1);
        check("rst_count",    32'(count),    0);
        check("rst_full",     32'(full),     0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_tx_start", 32'(tx_start), 0);
        @(negedge sys_clk);
        check("en_send_rise", 32'(en_send), 1);

        // Level held for two cycles writes once; start pulse two cycles after the edge.
        @(negedge sys_clk);
        wr_en   = 1'b1;
        wr_data = 8'h00;
        @(negedge sys_clk);
        check("t2_count1", 32'(count), 1);
        @(negedge sys_clk);
        wr_en = 1'b0;
        check("t2_count0",  32'(count),    0);
        check("t2_nostart", 32'(tx_start), 0);
        @(negedge sys_clk);
        check("t2_start", 32'(tx_start), 1);
        check("t2_data",  32'(tx_data),  0);
        @(negedge sys_clk);
        check("t2_start_width", 32'(tx_start), 0);
        repeat (10) @(negedge sys_clk);

        // Fill with the UART stalled; byte 1 is taken by the sender, so 257 bytes fill it.
        busy_mode = 1;
        for (int k = 1; k <= 257; k++) begin
            push_byte(8'(k - 1));
            if (k == 252) check("af_en_high", 32'(en_send), 1);
            if (k == 253) begin
                check("af_count",   32'(count),   252);
                check("af_en_low",  32'(en_send), 0);
            end
            if (k == 256) check("nearly_full", 32'(full), 0);
            if (k == 257) begin
                check("full_count", 32'(count), 256);
                check("full_flag",  32'(full),  1);
            end
        end

        // Release busy so the sender pops on the same edge as a new write edge.
        busy_mode = 2;
        @(negedge sys_clk);
        @(negedge sys_clk);
        wr_en     = 1'b1;
        wr_data   = 8'hA5;
        busy_mode = 1;
        @(negedge sys_clk);
        wr_en = 1'b0;
        check("simul_count", 32'(count),    256);
        check("simul_ovf",   32'(overflow), 0);
        check("simul_full",  32'(full),     1);

        push_byte(8'hEE);
        check("ovf_flag",  32'(overflow), 1);
        check("ovf_count", 32'(count),    256);

        // Drain in order with 10-cycle busy pulses.
        busy_mode = 0;
        busy_len  = 10;
        wait_idle(8000, "drain");
        check("drain_empty", 32'(empty), 1);
        check("drain_count", 32'(count), 0);
        check("drain_ovf",   32'(overflow), 1);

        for (int i = 0; i < 3; i++) push_byte(8'($urandom));
        wait_idle(200, "wrap");

        // Random write edges against random busy pulse lengths.
        busy_mode = 3;
        for (int i = 0; i < 3000; i++) begin
            @(negedge sys_clk);
            wr_en   = ($urandom_range(0, 2) != 0);
            wr_data = 8'($urandom);
        end
        @(negedge sys_clk);
        wr_en = 1'b0;
        wait_idle(10000, "random");

        // Reset while the sender waits for the UART to finish.
        busy_mode = 0;
        busy_len  = 10;
        push_byte(8'h3C);
        n = 0;
        while (tx_start !== 1'b1 && n < 20) begin
            @(negedge sys_clk);
            n++;
        end
        check("rt_start_seen", 32'(n < 20), 1);
        check("rt_start_data", 32'(tx_data), 32'h3C);
        push_byte(8'h11);
        push_byte(8'h22);
        check("rt_pre_count", 32'(count), 2);
        #2;
        sys_rst = 1'b1;
        #1;
        check("rt_tx_start", 32'(tx_start), 0);
        check("rt_count",    32'(count),    0);
        check("rt_overflow", 32'(overflow), 0);
        check("rt_empty",    32'(empty),    1);
        check("rt_en_send",  32'(en_send),  0);
        check("rt_tx_data",  32'(tx_data),  0);
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        push_byte(8'h5A);
        @(negedge sys_clk);
        check("rt_idle_nostart", 32'(tx_start), 0);
        @(negedge sys_clk);
        check("rt_idle_start", 32'(tx_start), 1);
        check("rt_idle_data",  32'(tx_data),  32'h5A);
        wait_idle(200, "final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
